// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the power-up reset sequencer.
package reset_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        StWaitLock,
        StCount,
        StDone
    } seq_state_e;

    // Default build: camera, capture, tracker released 300, 500, 1000 cycles apart
    localparam int unsigned DefNumStages  = 3;
    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefLockFilter = 4;
    localparam logic [DefNumStages*DefCntW-1:0] DefStageDelays = {16'd1000, 16'd500, 16'd300};

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Delay counter: counts while enabled, flags the cycle on which it reaches the limit.
module seq_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    // Expiry is combinational so the FSM acts on the very edge the count matches
    always_comb begin
        w_expired = i_en && (r_cnt == i_limit);
    end

    // Counter restarts from zero on clear or expiry, so it can never wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_expired) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = w_expired;

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: qualifies PLL lock, then releases active-low stage
// resets in order, each after its own delay. Lock loss or restart re-runs it.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned                   NUM_STAGES   = DefNumStages,
    parameter int unsigned                   CNT_W        = DefCntW,
    parameter logic [NUM_STAGES*CNT_W-1:0]   STAGE_DELAYS = DefStageDelays,
    parameter int unsigned                   LOCK_FILTER  = DefLockFilter
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_lock_in,
    input  logic                  i_restart,
    output logic [NUM_STAGES-1:0] o_stage_resetn,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned FiltW  = $clog2(LOCK_FILTER + 1);
    localparam int unsigned StageW = $clog2(NUM_STAGES + 1);
    localparam logic [FiltW-1:0]  FiltLast  = FiltW'(LOCK_FILTER - 1);
    localparam logic [StageW-1:0] LastStage = StageW'(NUM_STAGES - 1);

    logic                  r_lock_meta;
    logic                  r_lock_q;
    logic [FiltW-1:0]      r_filter;
    seq_state_e            r_state;
    logic [StageW-1:0]     r_stage;
    logic [NUM_STAGES-1:0] r_stage_resetn;
    logic                  r_busy;
    logic                  r_done;

    logic [CNT_W-1:0]      w_delay;
    logic [CNT_W-1:0]      w_limit;
    logic [NUM_STAGES-1:0] w_stage_onehot;
    logic                  w_abort;
    logic                  w_timer_en;
    logic                  w_timer_clear;
    logic                  w_expired;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lock_meta <= 1'b0;
            r_lock_q    <= 1'b0;
        end else begin
            r_lock_meta <= i_lock_in;
            r_lock_q    <= r_lock_meta;
        end
    end

    // Select current stage delay; a zero delay behaves as one cycle
    always_comb begin
        w_delay        = '0;
        w_stage_onehot = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_stage == StageW'(k)) begin
                w_delay           = STAGE_DELAYS[k*CNT_W +: CNT_W];
                w_stage_onehot[k] = 1'b1;
            end
        end
        w_limit = (w_delay == '0) ? '0 : w_delay - CNT_W'(1);
    end

    // Abort when lock drops or a restart arrives once the sequence has started
    always_comb begin
        w_abort       = (r_state != StWaitLock) && (!r_lock_q || i_restart);
        w_timer_en    = (r_state == StCount);
        w_timer_clear = (r_state != StCount) || w_abort;
    end

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_timer_clear),
        .i_en      (w_timer_en),
        .i_limit   (w_limit),
        .o_expired (w_expired)
    );

    // Sequencer FSM with registered outputs; abort outranks a same-edge release
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= StWaitLock;
            r_filter       <= '0;
            r_stage        <= '0;
            r_stage_resetn <= '0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
        end else begin
            unique case (r_state)
                StWaitLock: begin
                    if (i_restart || !r_lock_q) begin
                        r_filter <= '0;
                    end else if (r_filter == FiltLast) begin
                        r_filter <= '0;
                        r_stage  <= '0;
                        r_state  <= StCount;
                    end else begin
                        r_filter <= r_filter + 1'b1;
                    end
                end
                StCount: begin
                    if (w_abort) begin
                        r_stage_resetn <= '0;
                        r_stage        <= '0;
                        r_filter       <= '0;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_state        <= StWaitLock;
                    end else if (w_expired) begin
                        // OR-ing in the current bit keeps the output a thermometer code
                        r_stage_resetn <= r_stage_resetn | w_stage_onehot;
                        r_stage        <= r_stage + 1'b1;
                        if (r_stage == LastStage) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (w_abort) begin
                        r_stage_resetn <= '0;
                        r_stage        <= '0;
                        r_filter       <= '0;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_state        <= StWaitLock;
                    end
                end
                default: begin
                    r_state <= StWaitLock;
                end
            endcase
        end
    end

    assign o_stage_resetn = r_stage_resetn;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default delays on dut_a, short delays on dut_b.
`timescale 1ns/1ps
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_a, lock_a, restart_a;
    logic [2:0] stage_a;
    logic       busy_a, done_a;
    logic       rst_b, lock_b, restart_b;
    logic [2:0] stage_b;
    logic       busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int n;

    always #12 clk = ~clk;

    reset_sequencer dut_a (
        .i_clk          (clk),
        .i_rst          (rst_a),
        .i_lock_in      (lock_a),
        .i_restart      (restart_a),
        .o_stage_resetn (stage_a),
        .o_busy         (busy_a),
        .o_done         (done_a)
    );

    reset_sequencer #(
        .NUM_STAGES   (3),
        .CNT_W        (16),
        .STAGE_DELAYS ({16'd0, 16'd2, 16'd0}),
        .LOCK_FILTER  (4)
    ) dut_b (
        .i_clk          (clk),
        .i_rst          (rst_b),
        .i_lock_in      (lock_b),
        .i_restart      (restart_b),
        .o_stage_resetn (stage_b),
        .o_busy         (busy_b),
        .o_done         (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic is_thermo(input logic [2:0] x);
        logic [3:0] v;
        v = {1'b0, x};
        return (((v + 4'd1) & v) == 4'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until dut_a output equals tgt; bound+1 on timeout
    task automatic wait_a(input logic [2:0] tgt, input int bound, output int cnt);
        cnt = 0;
        while (stage_a !== tgt && cnt <= bound) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_b(input logic [2:0] tgt, input int bound, output int cnt);
        cnt = 0;
        while (stage_b !== tgt && cnt <= bound) begin
            tick();
            cnt++;
        end
    endtask

    // Thermometer invariant on both instances, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_a === 1'b0) chk("thermo_a", 32'(is_thermo(stage_a)), 32'd1);
        if (rst_b === 1'b0) chk("thermo_b", 32'(is_thermo(stage_b)), 32'd1);
    end

    initial begin
        rst_a = 1'b1; lock_a = 1'b0; restart_a = 1'b0;
        rst_b = 1'b1; lock_b = 1'b0; restart_b = 1'b0;
        tick(); tick();
        chk("reset_stage", 32'(stage_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd1);
        chk("reset_done", 32'(done_a), 32'd0);

        // Test 1: counting the lock-sampling edge as edge 1: 2 sync + 4 filter + 300
        rst_a = 1'b0;
        tick();
        lock_a = 1'b1;
        wait_a(3'b001, 400, n);  chk("t1_rel0_edges", 32'(n), 32'd306);
        chk("t1_busy_mid", 32'(busy_a), 32'd1);
        wait_a(3'b011, 600, n);  chk("t1_rel1_edges", 32'(n), 32'd500);
        wait_a(3'b111, 1100, n); chk("t1_rel2_edges", 32'(n), 32'd1000);
        chk("t1_done", 32'(done_a), 32'd1);
        chk("t1_busy", 32'(busy_a), 32'd0);
        repeat (5) tick();
        chk("t1_hold", 32'(stage_a), 32'd7);

        // Test 4: restart in DONE, lock held
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        chk("t4_stage", 32'(stage_a), 32'd0);
        chk("t4_done", 32'(done_a), 32'd0);
        chk("t4_busy", 32'(busy_a), 32'd1);
        wait_a(3'b001, 400, n);  chk("t4_rel0_edges", 32'(n), 32'd304);

        // Test 3: lock falls while 011; abort lands on third edge
        wait_a(3'b011, 600, n);  chk("t3_rel1_edges", 32'(n), 32'd500);
        lock_a = 1'b0;
        tick(); tick();
        chk("t3_hold2", 32'(stage_a), 32'd3);
        tick();
        chk("t3_stage", 32'(stage_a), 32'd0);
        chk("t3_done", 32'(done_a), 32'd0);
        chk("t3_busy", 32'(busy_a), 32'd1);
        lock_a = 1'b1;
        wait_a(3'b001, 400, n);  chk("t3_rerun0", 32'(n), 32'd306);
        wait_a(3'b011, 600, n);  chk("t3_rerun1", 32'(n), 32'd500);
        wait_a(3'b111, 1100, n); chk("t3_rerun2", 32'(n), 32'd1000);
        chk("t3_rerun_done", 32'(done_a), 32'd1);

        // Test 2: glitch low over edge 4; filter restarts, qualify moves from edge 6 to 10
        lock_a = 1'b0;
        repeat (4) tick();
        chk("t2_dropped", 32'(stage_a), 32'd0);
        lock_a = 1'b1;
        repeat (3) tick();
        lock_a = 1'b0;
        tick();
        lock_a = 1'b1;
        wait_a(3'b001, 400, n);  chk("t2_rel0_edges", 32'(n + 4), 32'd310);

        // Test 6: async rst between edges mid-COUNT
        repeat (100) tick();
        #5;
        rst_a = 1'b1;
        #1;
        chk("t6_async_stage", 32'(stage_a), 32'd0);
        chk("t6_async_busy", 32'(busy_a), 32'd1);
        chk("t6_async_done", 32'(done_a), 32'd0);
        tick(); tick();
        rst_a = 1'b0;
        wait_a(3'b001, 400, n);  chk("t6_rerun0", 32'(n), 32'd306);
        // Restart plus lock loss on the exact edge of the stage-1 release
        repeat (499) tick();
        chk("t6_prerelease", 32'(stage_a), 32'd1);
        restart_a = 1'b1;
        lock_a    = 1'b0;
        tick();
        restart_a = 1'b0;
        chk("t6_abort_stage", 32'(stage_a), 32'd0);
        chk("t6_abort_done", 32'(done_a), 32'd0);
        chk("t6_abort_busy", 32'(busy_a), 32'd1);
        repeat (3) tick();
        chk("t6_abort_hold", 32'(stage_a), 32'd0);

        // Restart in WAIT_LOCK clears the filter: qualify moves from edge 6 to 9
        lock_a = 1'b1;
        repeat (4) tick();
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        wait_a(3'b001, 400, n);  chk("t_wl_restart", 32'(n + 5), 32'd309);

        // Test 5: delays {0,2,0} give gaps 1, 2, 1
        rst_b = 1'b0;
        tick();
        lock_b = 1'b1;
        wait_b(3'b001, 50, n);   chk("t5_rel0_edges", 32'(n), 32'd7);
        wait_b(3'b011, 50, n);   chk("t5_gap1", 32'(n), 32'd2);
        wait_b(3'b111, 50, n);   chk("t5_gap2", 32'(n), 32'd1);
        chk("t5_done", 32'(done_b), 32'd1);
        chk("t5_busy", 32'(busy_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
